// File: rtl/traffic_pkg.sv
// Shared light codes and detector state encoding for the signal controller
// and its country-road vehicle detector.
package traffic_pkg;

  typedef enum logic [1:0] {
    RED    = 2'd0,
    YELLOW = 2'd1,
    GREEN  = 2'd2
  } light_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    QUALIFY = 3'd1,
    REQUEST = 3'd2,
    SERVING = 3'd3,
    RELEASE = 3'd4
  } det_state_t;

endpackage

// File: rtl/bit_sync.sv
// Two-flop synchroniser with synchronous active-high clear, for asynchronous
// pad inputs.
module bit_sync (
  input  logic clock,
  input  logic clear,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/vehicle_detector.sv
// Debounced, held country-road request for the signal controller, with a
// service counter. Optional starvation alarm: VEHICLE_DETECTOR_STARVE_ALARM_EN.
module vehicle_detector
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int STARVE_LIMIT    = 64
) (
  input  logic       clock,
  input  logic       clear,
  input  logic       loop_raw,
  input  logic [1:0] cntry,
  output logic       x,
  output logic [7:0] served_cnt,
  output logic       starve_alarm
);

  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 255) begin : g_bad_debounce
    $error("vehicle_detector: DEBOUNCE_CYCLES must be in 2..255");
  end
  if (STARVE_LIMIT < 1) begin : g_bad_starve
    $error("vehicle_detector: STARVE_LIMIT must be at least 1");
  end

  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

  logic       s;
  det_state_t state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] served_q, served_d;
  logic       x_q, x_d;
  logic       not_green;

  bit_sync u_loop_sync (
    .clock (clock),
    .clear (clear),
    .d     (loop_raw),
    .q     (s)
  );

  assign not_green = (cntry != GREEN);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    served_d = served_q;
    unique case (state_q)
      IDLE: begin
        if (s) begin
          state_d = QUALIFY;
          cnt_d   = 8'd1;
        end else begin
          cnt_d = 8'd0;
        end
      end
      QUALIFY: begin
        if (!s) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = REQUEST;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      REQUEST: begin
        if (!not_green) begin
          state_d = SERVING;
          cnt_d   = 8'd0;
        end
      end
      SERVING: begin
        // The controller ending green outranks a debounce release in the same cycle.
        if (not_green) begin
          served_d = served_q + 8'd1;
          cnt_d    = 8'd0;
          state_d  = s ? REQUEST : IDLE;
        end else if (s) begin
          cnt_d = 8'd0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = RELEASE;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RELEASE: begin
        if (not_green) begin
          state_d  = IDLE;
          served_d = served_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase
    x_d = (state_d == REQUEST) || (state_d == SERVING);
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q  <= IDLE;
      cnt_q    <= 8'd0;
      served_q <= 8'd0;
      x_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      served_q <= served_d;
      x_q      <= x_d;
    end
  end

  assign x          = x_q;
  assign served_cnt = served_q;

`ifdef VEHICLE_DETECTOR_STARVE_ALARM_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  logic [SW-1:0] starve_cnt_q, starve_cnt_d;
  logic          alarm_q, alarm_d;

  always_comb begin
    starve_cnt_d = '0;
    if (state_d == REQUEST) begin
      starve_cnt_d = (starve_cnt_q == STARVE_MAX) ? starve_cnt_q : starve_cnt_q + SW'(1);
    end
    alarm_d = alarm_q || (starve_cnt_d == STARVE_MAX);
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      starve_cnt_q <= '0;
      alarm_q      <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      alarm_q      <= alarm_d;
    end
  end

  assign starve_alarm = alarm_q;
`else
  assign starve_alarm = 1'b0;
`endif

endmodule
